// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core store port and memory32.
// Latency: a store pushed on edge N is presented at the drain port from cycle N+1.
// Backpressure: out_write_ready drops when full (registered count only); stores offered while full are dropped and flagged.
//
// Ports:
//   CLK, RESET                          clock, synchronous active-high reset
//   in_write_*  / out_write_ready       core store request and acceptance
//   in_read_address / out_forward_*     word-granular read-after-write forwarding
//   out_mem_write_* / in_mem_write_ready drain of the head entry into memory32
//   out_empty, out_count, out_overflow  occupancy and sticky drop flag
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_write_enable,
  input  logic [31:0]      in_write_address,
  input  logic [31:0]      in_write_data,
  output logic             out_write_ready,
  input  logic [31:0]      in_read_address,
  output logic             out_forward_hit,
  output logic [31:0]      out_forward_data,
  output logic             out_mem_write_enable,
  output logic [31:0]      out_mem_write_address,
  output logic [31:0]      out_mem_write_data,
  input  logic             in_mem_write_ready,
  output logic             out_empty,
  output logic [PTR_W:0]   out_count,
  output logic             out_overflow
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [PTR_W-1:0] w_idx;

  // Readiness looks only at the registered count, so a same-cycle pop
  // never makes room for a same-cycle push.
  assign out_write_ready = (r_count < LP_DEPTH);
  assign w_push = in_write_enable && out_write_ready;
  assign w_drop = in_write_enable && !out_write_ready;

  // Reset overrides everything in its cycle, including the drain strobe,
  // so memory never sees a write that the buffer is about to forget.
  assign w_pop = (r_count != '0) && in_mem_write_ready && !RESET;

  assign out_mem_write_enable  = w_pop;
  assign out_mem_write_address = r_addr[r_head];
  assign out_mem_write_data    = r_data[r_head];
  assign out_empty             = (r_count == '0);
  assign out_count             = r_count;
  assign out_overflow          = r_overflow;

  // Walk entries oldest to youngest so the last match wins, giving the
  // youngest matching store. Only registered entries are considered.
  always_comb begin
    out_forward_hit  = 1'b0;
    out_forward_data = '0;
    w_idx            = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < r_count) &&
          (r_addr[w_idx][31:2] == in_read_address[31:2])) begin
        out_forward_hit  = 1'b1;
        out_forward_data = r_data[w_idx];
      end
    end
  end

  // Entry payload needs no reset; validity comes from the pointers/count.
  always_ff @(posedge CLK) begin
    if (w_push && !RESET) begin
      r_addr[r_tail] <= in_write_address;
      r_data[r_tail] <= in_write_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule
